// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply,
// restoring divide, sign fix-up in a single trailing cycle.
module mdu_iterative #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_f3;
  logic [N-1:0]   r_op;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*N-1:0] r_prod;   // mul: {acc, multiplier}; div: {rem, quot}
  logic           r_neg_q;  // negate product / quotient
  logic           r_neg_r;  // negate remainder (dividend was negative)

  logic           w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [N-1:0]   w_a_mag, w_b_mag;
  logic           w_div0, w_ovf, w_spec;
  logic [N-1:0]   w_spec_val;
  logic [N:0]     w_mul_sum, w_shrem, w_diff;
  logic [2*N-1:0] w_prod_nxt, w_prod_neg;
  logic [N-1:0]   w_quot, w_rem, w_fix_res;

  // Operand signedness decode; every funct3 encoding is covered.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
      3'b010:                         begin w_a_sgn = 1'b1; w_b_sgn = 1'b0; end
      default:                        begin w_a_sgn = 1'b0; w_b_sgn = 1'b0; end
    endcase
  end

  assign w_a_neg = w_a_sgn & rs1[N-1];
  assign w_b_neg = w_b_sgn & rs2[N-1];
  assign w_a_mag = w_a_neg ? -rs1 : rs1;
  assign w_b_mag = w_b_neg ? -rs2 : rs2;

  // Divide corner cases resolved at accept time without iterating.
  assign w_div0     = funct3[2] && (rs2 == '0);
  assign w_ovf      = funct3[2] && !funct3[0] && (rs1 == {1'b1, {(N-1){1'b0}}}) && (rs2 == '1);
  assign w_spec     = w_div0 | w_ovf;
  assign w_spec_val = funct3[1] ? (w_div0 ? rs1 : '0) : (w_div0 ? '1 : rs1);

  // One iteration step for both algorithms.
  assign w_mul_sum = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_op} : '0);
  assign w_shrem   = {r_prod[2*N-1:N], r_prod[N-1]};
  assign w_diff    = w_shrem - {1'b0, r_op};

  always_comb begin
    w_prod_nxt = r_prod;
    if (!r_f3[2])
      w_prod_nxt = {w_mul_sum, r_prod[N-1:1]};
    else if (w_diff[N])
      w_prod_nxt = {w_shrem[N-1:0], r_prod[N-2:0], 1'b0};
    else
      w_prod_nxt = {w_diff[N-1:0], r_prod[N-2:0], 1'b1};
  end

  // Sign fix-up and result selection.
  assign w_prod_neg = -r_prod;
  assign w_quot     = r_neg_q ? -r_prod[N-1:0]     : r_prod[N-1:0];
  assign w_rem      = r_neg_r ? -r_prod[2*N-1:N]   : r_prod[2*N-1:N];

  always_comb begin
    w_fix_res = '0;
    case (r_f3)
      3'b000:                 w_fix_res = r_neg_q ? w_prod_neg[N-1:0] : r_prod[N-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = r_neg_q ? w_prod_neg[2*N-1:N] : r_prod[2*N-1:N];
      3'b100, 3'b101:         w_fix_res = w_quot;
      default:                w_fix_res = w_rem;
    endcase
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_op    <= '0;
      r_prod  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      // Abort wins over any start in the same cycle; result is kept.
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
          if (start) begin
            r_f3    <= funct3;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_op    <= funct3[2] ? w_b_mag : w_a_mag;
            r_prod  <= {{N{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
            if (w_spec) begin
              result  <= w_spec_val;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(N-1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          result  <= w_fix_res;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
